// File: rtl/dmem_store_buffer.sv
// M-stage data-memory bridge: stores retire into a DEPTH-entry FIFO and drain to a valid/ready word port; loads stall the core until ReadData lands.
// `define STORE_FWD_CHECK_EN lets loads bypass queued stores to other words; otherwise every load waits for a full drain.
module dmem_store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic            MemRead,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteData,
  input  logic [XLEN-1:0] mask,
  output logic [XLEN-1:0] ReadData,
  output logic            stallM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, DRAIN, REQ, RESP, DONE} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  addr_d [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [3:0]       strb_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             wpend_q, wpend_d;

  logic [XLEN-1:0]  waddr;
  logic [3:0]       st_strb;
  logic             empty, full, blocked, load_wants, drain_en, go_req, push, pop;
  logic             unused_bits;

  assign waddr       = {ALUResultM[XLEN-1:2], 2'b00};
  assign st_strb     = {mask[24], mask[16], mask[8], mask[0]};
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign unused_bits = ^{mask, ALUResultM[1:0]};

`ifdef STORE_FWD_CHECK_EN
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == waddr)) blocked = 1'b1;
    end
  end
`else
  always_comb begin
    blocked = !empty;
  end
`endif

  // A store already shown on the bus keeps it until accepted, even if a load wants the port.
  always_comb begin
    load_wants = ((state_q == IDLE) && MemRead && !blocked) || ((state_q == DRAIN) && !blocked);
    drain_en   = !empty && (state_q inside {IDLE, DRAIN, DONE}) && !(load_wants && !wpend_q);
    go_req     = load_wants && !(drain_en && !mem_ready);
    stallM     = (MemWrite && full) || ((state_q == IDLE) && MemRead) ||
                 (state_q inside {DRAIN, REQ, RESP});
    push       = MemWrite && !stallM;
    pop        = drain_en && mem_ready;
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:    if (MemRead) state_d = go_req ? REQ : DRAIN;
      DRAIN:   if (go_req) state_d = REQ;
      REQ:     if (mem_ready) state_d = RESP;
      RESP: begin
        if (mem_rvalid) begin
          state_d = DONE;
          rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    wpend_d = drain_en && !mem_ready;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      addr_d[tail_q] = waddr;
      data_d[tail_q] = WriteData;
      strb_d[tail_q] = st_strb;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      wpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      wpend_q <= wpend_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

  assign ReadData  = rdata_q;
  assign mem_req   = drain_en || (state_q == REQ);
  assign mem_we    = drain_en;
  assign mem_addr  = drain_en ? addr_q[head_q] : waddr;
  assign mem_wdata = data_q[head_q];
  assign mem_wstrb = drain_en ? strb_q[head_q] : 4'b0000;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: program-order memory image vs. bus-side memory image, store queue scoreboard,
// plus directed store/load sequences with literal expectations.
`timescale 1ns/1ps
module tb_dmem_store_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            MemWrite = 1'b0, MemRead = 1'b0;
  logic [XLEN-1:0] ALUResultM = '0, WriteData = '0, mask = '0;
  logic [XLEN-1:0] ReadData;
  logic            stallM, mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUResultM(ALUResultM), .WriteData(WriteData), .mask(mask),
    .ReadData(ReadData), .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] d; logic [3:0] s; } st_t;
  st_t         exp_q[$];
  logic [31:0] bus_mem  [logic [31:0]];
  logic [31:0] arch_mem [logic [31:0]];
  logic [31:0] log_a[$];
  logic        log_we[$];
  int          checks = 0, errors = 0;
  int          rv_delay = 1, rd_wait = 0;
  logic [31:0] rd_val = '0;
  logic        hold_prev = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic [3:0]  h_strb = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'h5A000000 ^ a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, then memory responder and model update.
  initial begin
    int hits;
    st_t e;
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        chk("hold_req", mem_req, 1);
        chk("hold_we", mem_we, h_we);
        chk("hold_addr", mem_addr, h_addr);
        chk("hold_strb", mem_wstrb, h_strb);
        if (h_we) chk("hold_wdata", mem_wdata, h_wdata);
      end
      if (!reset && !MemRead)
        chk("stall_rule", stallM, MemWrite && (exp_q.size() == DEPTH));
      if (mem_req && mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_order: got write to %h expected no write (model queue empty)", mem_addr);
        end else begin
          e = exp_q[0];
          chk("write_addr", mem_addr, e.a);
          chk("write_data", mem_wdata, e.d);
          chk("write_strb", mem_wstrb, e.s);
        end
      end
      if (mem_req && !mem_we) begin
        chk("read_needs_load", MemRead, 1);
        chk("read_addr", mem_addr, {ALUResultM[31:2], 2'b00});
        hits = 0;
        foreach (exp_q[i]) if (exp_q[i].a == {ALUResultM[31:2], 2'b00}) hits++;
`ifdef STORE_FWD_CHECK_EN
        chk("read_past_matching_store", hits, 0);
`else
        chk("read_before_full_drain", exp_q.size(), 0);
`endif
      end
      if (!reset && MemRead && !stallM)
        chk("load_data", ReadData, arch_rd({ALUResultM[31:2], 2'b00}));

      hold_prev = mem_req && !mem_ready && !reset;
      h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata; h_strb = mem_wstrb;

      mem_rvalid = 1'b0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_val;
        end
      end
      if (mem_req && mem_ready) begin
        log_a.push_back(mem_addr);
        log_we.push_back(mem_we);
        if (mem_we) begin
          bus_mem[mem_addr] = merge(bus_rd(mem_addr), mem_wdata, mem_wstrb);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          rd_wait = rv_delay;
          rd_val  = bus_rd(mem_addr);
        end
      end
      if (!reset && MemWrite && !stallM) begin
        e.a = {ALUResultM[31:2], 2'b00};
        e.d = WriteData;
        e.s = {mask[24], mask[16], mask[8], mask[0]};
        exp_q.push_back(e);
        arch_mem[e.a] = merge(arch_rd(e.a), e.d, e.s);
      end
      if (reset) begin
        exp_q.delete();
        arch_mem = bus_mem;
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m, output int sc);
    int n;
    MemWrite = 1'b1; ALUResultM = a; WriteData = d; mask = m;
    sc = 0; n = 0;
    @(negedge clk);
    while (stallM && n < 200) begin
      sc++; n++;
      @(negedge clk);
    end
    if (n >= 200) chk("store_timeout", stallM, 0);
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int sc);
    int n;
    MemRead = 1'b1; ALUResultM = a;
    sc = 0; n = 0;
    @(negedge clk);
    while (stallM && n < 200) begin
      sc++; n++;
      @(negedge clk);
    end
    if (n >= 200) chk("load_timeout", stallM, 0);
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", stallM, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rdata", ReadData, 0);

    // Fill the buffer with the port blocked, then overflow by one.
    @(posedge clk); #1;
    log_a.delete(); log_we.delete();
    for (int k = 0; k < 4; k++) begin
      do_store(32'h100 + 32'(4*k), 32'h11111111 * (k + 1), 32'hFFFFFFFF, sc);
      chk("fill_no_stall", sc, 0);
    end
    fork
      do_store(32'h110, 32'h55555555, 32'hFFFFFFFF, sc);
      begin
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
      end
    join
    chk("full_stall_cycles", sc, 4);
    mem_ready = 1'b1;
    wait_drain();
    chk("drain_count", log_a.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_a.size()) begin
        chk("drain_order_addr", log_a[k], 32'h100 + 32'(4*k));
        chk("drain_order_we", log_we[k], 1);
      end
    end

    // Byte store to an unaligned address.
    mem_ready = 1'b0;
    do_store(32'h201, 32'h0000AB00, 32'h0000FF00, sc);
    @(negedge clk);
    chk("sb_req", mem_req, 1);
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_strb", mem_wstrb, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'h0000AB00);
    @(posedge clk); #1 mem_ready = 1'b1;
    wait_drain();

    // Minimum-latency loads.
    bus_mem[32'h300] = 32'hDEADBEEF;
    arch_mem[32'h300] = 32'hDEADBEEF;
    do_load(32'h300, sc);
    chk("load_min_stall", sc, 3);
    chk("load_deadbeef", ReadData, 32'hDEADBEEF);
    do_load(32'h200, sc);
    chk("load2_stall", sc, 3);
    chk("load_byte_merged", ReadData, 32'h5A00AB00);

    // Load behind a queued store to a different word, then to the same word.
    log_a.delete(); log_we.delete();
    do_store(32'h400, 32'hCAFEF00D, 32'hFFFFFFFF, sc);
    do_load(32'h500, sc);
    chk("bypass_load_data", ReadData, 32'h5A000500);
    wait_drain();
    if (log_a.size() >= 2) begin
`ifdef STORE_FWD_CHECK_EN
      chk("fwd_first_addr", log_a[0], 32'h500);
      chk("fwd_first_we", log_we[0], 0);
      chk("fwd_second_addr", log_a[1], 32'h400);
`else
      chk("nofwd_first_addr", log_a[0], 32'h400);
      chk("nofwd_first_we", log_we[0], 1);
      chk("nofwd_second_addr", log_a[1], 32'h500);
`endif
    end else chk("bypass_log_len", log_a.size(), 2);
    log_a.delete(); log_we.delete();
    do_store(32'h400, 32'h12345678, 32'hFFFFFFFF, sc);
    do_load(32'h400, sc);
    chk("raw_load_data", ReadData, 32'h12345678);
    if (log_a.size() >= 2) begin
      chk("raw_first_we", log_we[0], 1);
      chk("raw_first_addr", log_a[0], 32'h400);
      chk("raw_second_we", log_we[1], 0);
    end else chk("raw_log_len", log_a.size(), 2);

    // Reset while waiting for read data; the late response must be ignored.
    rv_delay = 4;
    MemRead = 1'b1; ALUResultM = 32'h600;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort_rdata", ReadData, 0);
    chk("abort_stall", stallM, 0);
    chk("abort_req", mem_req, 0);
    @(posedge clk); #1;
    rv_delay = 1;
    do_load(32'h600, sc);
    chk("post_reset_stall", sc, 3);
    chk("post_reset_load", ReadData, 32'h5A000600);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
